// File: rtl/data_cache_sa_wb.sv
// data_cache_sa_wb
// ----------------
// Set-associative, write-back, write-allocate data cache with a 1024-word
// backing RAM behind it. It replaces the processor data memory directly.
// Hits complete on the request edge. A miss raises clk_stall, which freezes
// the pipeline, until the line has been (optionally) written back and refilled.
//
// Parameters:
//   WAYS        associativity (power of 2, 1..8)
//   SETS        number of sets (power of 2)
//   LINE_WORDS  32-bit words per line (power of 2)
//   MEM_WORDS   backing RAM depth in words, addressed by addr[11:2]
//   INIT_FILE   name of the RAM image that the integration environment loads
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   addr         14-bit byte address; 14'h2000 with memwrite writes the LED register
//   write_data   store data (byte/half taken from the LSBs)
//   memwrite     store request (wins when memread is also set)
//   memread      load request
//   sign_mask    [3] sign-extend, [2] word, [1] half-or-word, otherwise byte
//   read_data    registered load result
//   led          LED register
//   clk_stall    registered, high while a miss is serviced
//   hit_count    IDLE hits   (only with DCACHE_STATS_EN defined)
//   miss_count   IDLE misses (only with DCACHE_STATS_EN defined)
//
// Optional feature macro: DCACHE_STATS_EN adds the hit/miss counters.

module data_cache_sa_wb #(
    parameter int WAYS       = 2,
    parameter int SETS       = 4,
    parameter int LINE_WORDS = 4,
    parameter int MEM_WORDS  = 1024,
    parameter     INIT_FILE  = "programs/data.hex"
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] addr,
    input  logic [31:0] write_data,
    input  logic        memwrite,
    input  logic        memread,
    input  logic [3:0]  sign_mask,
    output logic [31:0] read_data,
    output logic [7:0]  led,
    output logic        clk_stall
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int WORD_BITS  = $clog2(LINE_WORDS);
    localparam int INDEX_BITS = $clog2(SETS);
    localparam int TAG_BITS   = 10 - WORD_BITS - INDEX_BITS;
    localparam int WW         = (WORD_BITS  > 0) ? WORD_BITS  : 1;
    localparam int IW         = (INDEX_BITS > 0) ? INDEX_BITS : 1;
    localparam int AW         = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int CW         = $clog2(LINE_WORDS + 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WRITEBACK = 2'd1;
    localparam logic [1:0] REFILL    = 2'd2;
    localparam logic [1:0] UPDATE    = 2'd3;

    logic [1:0]          state;
    logic [CW-1:0]       cnt;
    logic [AW-1:0]       victim;
    logic [11:0]         lat_addr;
    logic [31:0]         lat_wdata;
    logic [3:0]          lat_mask;
    logic                lat_store;
    logic [7:0]          led_reg;

    logic [TAG_BITS-1:0] tag_mem  [WAYS][SETS];
    logic                valid    [WAYS][SETS];
    logic                dirty    [WAYS][SETS];
    logic [AW-1:0]       age      [WAYS][SETS];
    logic [31:0]         data_mem [WAYS][SETS][LINE_WORDS];

    logic [31:0]         ram [MEM_WORDS];
    logic [31:0]         ram_q;

    // Byte lane extraction for loads: halves picked by addr[1], bytes by the full offset.
    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] off,
                                                 input logic [3:0] m);
        logic [15:0] half_v;
        logic [7:0]  byte_v;
        half_v = off[1] ? w[31:16] : w[15:0];
        byte_v = w[{off, 3'b000} +: 8];
        if (m[2])
            return w;
        else if (m[1])
            return m[3] ? {{16{half_v[15]}}, half_v} : {16'h0, half_v};
        else
            return m[3] ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
    endfunction

    // Merge only the addressed bytes of a store into the existing word.
    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [1:0] off, input logic [3:0] m);
        logic [3:0]  be;
        logic [31:0] src;
        logic [31:0] res;
        if (m[2]) begin
            be  = 4'hF;
            src = wd;
        end else if (m[1]) begin
            be  = off[1] ? 4'b1100 : 4'b0011;
            src = {2{wd[15:0]}};
        end else begin
            be  = 4'b0001 << off;
            src = {4{wd[7:0]}};
        end
        for (int b = 0; b < 4; b++)
            res[8*b +: 8] = be[b] ? src[8*b +: 8] : old[8*b +: 8];
        return res;
    endfunction

    // RAM word address of word w of the line identified by (tag, set).
    function automatic logic [9:0] line_addr(input logic [TAG_BITS-1:0] t, input logic [IW-1:0] s,
                                             input logic [WW-1:0] w);
        logic [31:0] full;
        full = (32'(t) << (INDEX_BITS + WORD_BITS)) | (32'(s) << WORD_BITS) | 32'(w);
        return full[9:0];
    endfunction

    // While idle the live request is decoded; during a miss the latched one is.
    logic [11:0]         cur_addr;
    logic [31:0]         cur_wdata;
    logic [3:0]          cur_mask;
    logic                cur_store;
    logic [9:0]          cur_waddr;
    logic [TAG_BITS-1:0] cur_tag;
    logic [IW-1:0]       cur_idx;
    logic [WW-1:0]       cur_word;
    logic [WW-1:0]       cnt_word;
    logic                led_sel;
    logic                cache_req;

    assign cur_addr  = (state == IDLE) ? addr[11:0] : lat_addr;
    assign cur_wdata = (state == IDLE) ? write_data : lat_wdata;
    assign cur_mask  = (state == IDLE) ? sign_mask  : lat_mask;
    assign cur_store = (state == IDLE) ? memwrite   : lat_store;
    assign cur_waddr = cur_addr[11:2];
    assign cur_word  = WW'(cur_waddr & 10'(LINE_WORDS - 1));
    assign cur_idx   = IW'((cur_waddr >> WORD_BITS) & 10'(SETS - 1));
    assign cur_tag   = TAG_BITS'(cur_waddr >> (WORD_BITS + INDEX_BITS));
    assign cnt_word  = WW'(cnt);

    assign led_sel   = (addr == 14'h2000) && memwrite;
    assign cache_req = (memread || memwrite) && !led_sel;
    assign led       = led_reg;

    // Tag lookup plus victim choice: the lowest invalid way, otherwise the LRU (age 0) way.
    logic          hit;
    logic [AW-1:0] hit_way;
    logic          has_inv;
    logic [AW-1:0] inv_way;
    logic [AW-1:0] lru_way;
    logic [AW-1:0] victim_c;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        has_inv = 1'b0;
        inv_way = '0;
        lru_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[w][cur_idx] && tag_mem[w][cur_idx] == cur_tag) begin
                hit     = 1'b1;
                hit_way = AW'(w);
            end
            if (age[w][cur_idx] == '0)
                lru_way = AW'(w);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[w][cur_idx]) begin
                has_inv = 1'b1;
                inv_way = AW'(w);
            end
        end
        victim_c = has_inv ? inv_way : lru_way;
    end

    // One access datapath serves both an idle hit and the replayed op after a refill.
    logic [AW-1:0] acc_way;
    logic [31:0]   acc_old;
    logic [31:0]   load_val;
    logic [31:0]   store_val;
    logic          idle_hit;
    logic          touch;
    logic          store_now;

    assign acc_way   = (state == IDLE) ? hit_way : victim;
    assign acc_old   = data_mem[acc_way][cur_idx][cur_word];
    assign load_val  = load_extract(acc_old, cur_addr[1:0], cur_mask);
    assign store_val = store_merge(acc_old, cur_wdata, cur_addr[1:0], cur_mask);
    assign idle_hit  = (state == IDLE) && cache_req && hit;
    assign touch     = idle_hit || (state == UPDATE);
    assign store_now = touch && cur_store;

    // Control: miss FSM, tag/valid/dirty/LRU state, registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            victim    <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_mask  <= '0;
            lat_store <= 1'b0;
            led_reg   <= '0;
            read_data <= '0;
            clk_stall <= 1'b0;
`ifdef DCACHE_STATS_EN
            hit_count  <= '0;
            miss_count <= '0;
`endif
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    valid[w][s]   <= 1'b0;
                    dirty[w][s]   <= 1'b0;
                    age[w][s]     <= AW'(w);
                    tag_mem[w][s] <= '0;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    if (led_sel) begin
                        led_reg <= write_data[7:0];
                    end else if (cache_req && hit) begin
                        if (memwrite)
                            dirty[hit_way][cur_idx] <= 1'b1;
                        else
                            read_data <= load_val;
`ifdef DCACHE_STATS_EN
                        hit_count <= hit_count + 32'd1;
`endif
                    end else if (cache_req) begin
                        lat_addr  <= addr[11:0];
                        lat_wdata <= write_data;
                        lat_mask  <= sign_mask;
                        lat_store <= memwrite;
                        victim    <= victim_c;
                        cnt       <= '0;
                        clk_stall <= 1'b1;
                        state     <= (valid[victim_c][cur_idx] && dirty[victim_c][cur_idx])
                                     ? WRITEBACK : REFILL;
`ifdef DCACHE_STATS_EN
                        miss_count <= miss_count + 32'd1;
`endif
                    end
                end
                WRITEBACK: begin
                    if (cnt == CW'(LINE_WORDS - 1)) begin
                        cnt   <= '0;
                        state <= REFILL;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                REFILL: begin
                    // One extra cycle drains the synchronous RAM read of the last word.
                    if (cnt == CW'(LINE_WORDS)) begin
                        cnt   <= '0;
                        state <= UPDATE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                UPDATE: begin
                    valid[victim][cur_idx]   <= 1'b1;
                    tag_mem[victim][cur_idx] <= cur_tag;
                    dirty[victim][cur_idx]   <= lat_store;
                    if (!lat_store)
                        read_data <= load_val;
                    clk_stall <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // The touched way becomes most recent; ways newer than it age by one.
            if (touch) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (AW'(w) == acc_way)
                        age[w][cur_idx] <= AW'(WAYS - 1);
                    else if (age[w][cur_idx] > age[acc_way][cur_idx])
                        age[w][cur_idx] <= age[w][cur_idx] - AW'(1);
                end
            end
        end
    end

    // Storage: line data and backing RAM carry no reset.
    always_ff @(posedge clk) begin
        if (state == WRITEBACK)
            ram[line_addr(tag_mem[victim][cur_idx], cur_idx, cnt_word)] <= data_mem[victim][cur_idx][cnt_word];
        if (state == REFILL) begin
            if (cnt != CW'(LINE_WORDS))
                ram_q <= ram[line_addr(cur_tag, cur_idx, cnt_word)];
            if (cnt != '0)
                data_mem[victim][cur_idx][WW'(cnt - CW'(1))] <= ram_q;
        end
        if (store_now)
            data_mem[acc_way][cur_idx][cur_word] <= store_val;
    end

endmodule

// File: tb/tb_data_cache_sa_wb.sv
module tb_data_cache_sa_wb;

    localparam int WAYS       = 2;
    localparam int SETS       = 4;
    localparam int LINE_WORDS = 4;
    localparam int MEM_WORDS  = 1024;

    localparam logic [3:0] M_LBU = 4'b0000;
    localparam logic [3:0] M_LB  = 4'b1000;
    localparam logic [3:0] M_LHU = 4'b0010;
    localparam logic [3:0] M_LH  = 4'b1010;
    localparam logic [3:0] M_LW  = 4'b0110;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] addr = '0;
    logic [31:0] write_data = '0;
    logic        memwrite = 1'b0;
    logic        memread = 1'b0;
    logic [3:0]  sign_mask = '0;
    logic [31:0] read_data;
    logic [7:0]  led;
    logic        clk_stall;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int checks = 0;
    int errors = 0;
    bit idle_check = 0;

    always #5 clk = ~clk;

    data_cache_sa_wb #(
        .WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LINE_WORDS), .MEM_WORDS(MEM_WORDS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .addr(addr),
        .write_data(write_data),
        .memwrite(memwrite),
        .memread(memread),
        .sign_mask(sign_mask),
        .read_data(read_data),
        .led(led),
        .clk_stall(clk_stall)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count(hit_count),
        .miss_count(miss_count)
`endif
    );

    // Reference model: CPU-visible memory, backing RAM image, and per-set line
    // bookkeeping with recency timestamps.
    logic [31:0] mem_true  [MEM_WORDS];
    logic [31:0] ram_model [MEM_WORDS];
    bit          m_valid [SETS][WAYS];
    bit          m_dirty [SETS][WAYS];
    int          m_tag   [SETS][WAYS];
    longint      m_stamp [SETS][WAYS];
    longint      now_stamp = 0;
    logic [31:0] exp_rd = '0;
    logic [7:0]  exp_led = '0;
    int          m_hits = 0;
    int          m_misses = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [13:0] a, input logic [3:0] m);
        int first;
        int nbits;
        logic [31:0] keep;
        logic [31:0] v;
        if (m[2]) return w;
        if (m[1]) begin
            first = a[1] ? 2 : 0;
            nbits = 16;
        end else begin
            first = int'(a[1:0]);
            nbits = 8;
        end
        keep = (32'h1 << nbits) - 32'h1;
        v = (w >> (8 * first)) & keep;
        if (m[3] && v[nbits - 1]) v = v | ~keep;
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [13:0] a, input logic [3:0] m);
        int first;
        int count;
        logic [31:0] res;
        res = old;
        if (m[2]) begin first = 0; count = 4; end
        else if (m[1]) begin first = a[1] ? 2 : 0; count = 2; end
        else begin first = int'(a[1:0]); count = 1; end
        for (int k = 0; k < count; k++)
            res[8*(first + k) +: 8] = wd[8*k +: 8];
        return res;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 0;
                m_dirty[s][w] = 0;
                m_tag[s][w]   = 0;
                m_stamp[s][w] = 0;
            end
        for (int i = 0; i < MEM_WORDS; i++) mem_true[i] = ram_model[i];
        exp_rd   = '0;
        exp_led  = '0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic model_access(input logic [13:0] a, input logic [31:0] wd, input logic we,
                                input logic [3:0] m, output int exp_stall);
        int wa, set, tag, way, base;
        longint oldest;
        exp_stall = 0;
        if (a == 14'h2000 && we) begin
            exp_led = wd[7:0];
        end else begin
            wa  = int'(a[11:2]);
            set = (wa / LINE_WORDS) % SETS;
            tag = wa / (LINE_WORDS * SETS);
            way = -1;
            for (int w = 0; w < WAYS; w++)
                if (m_valid[set][w] && m_tag[set][w] == tag) way = w;
            if (way >= 0) begin
                m_hits++;
            end else begin
                m_misses++;
                for (int w = WAYS - 1; w >= 0; w--)
                    if (!m_valid[set][w]) way = w;
                if (way < 0) begin
                    oldest = m_stamp[set][0];
                    way = 0;
                    for (int w = 1; w < WAYS; w++)
                        if (m_stamp[set][w] < oldest) begin oldest = m_stamp[set][w]; way = w; end
                end
                if (m_valid[set][way] && m_dirty[set][way]) begin
                    exp_stall = 2 * LINE_WORDS + 2;
                    base = (m_tag[set][way] * SETS + set) * LINE_WORDS;
                    for (int k = 0; k < LINE_WORDS; k++) ram_model[base + k] = mem_true[base + k];
                end else begin
                    exp_stall = LINE_WORDS + 2;
                end
                m_valid[set][way] = 1;
                m_dirty[set][way] = 0;
                m_tag[set][way]   = tag;
            end
            now_stamp++;
            m_stamp[set][way] = now_stamp;
            if (we) begin
                mem_true[wa] = model_store(mem_true[wa], wd, a, m);
                m_dirty[set][way] = 1;
            end else begin
                exp_rd = model_load(mem_true[wa], a, m);
            end
        end
    endtask

    // Issue one request, wait out any stall (bounded), then compare against the model.
    task automatic applyStimulus(input logic [13:0] a, input logic [31:0] wd, input logic we,
                                 input logic re, input logic [3:0] m, output int stall_cnt);
        int exp_stall;
        idle_check = 0;
        model_access(a, wd, we, m, exp_stall);
        @(negedge clk);
        addr = a; write_data = wd; memwrite = we; memread = re; sign_mask = m;
        @(posedge clk);
        #1;
        stall_cnt = 0;
        while (clk_stall === 1'b1 && stall_cnt < 100) begin
            stall_cnt++;
            @(posedge clk);
            #1;
        end
        memwrite = 1'b0;
        memread  = 1'b0;
        checkOutput("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
        checkOutput("read_data", read_data, exp_rd);
        checkOutput("led", {24'h0, led}, {24'h0, exp_led});
`ifdef DCACHE_STATS_EN
        checkOutput("hit_count", hit_count, 32'(m_hits));
        checkOutput("miss_count", miss_count, 32'(m_misses));
`endif
        idle_check = 1;
    endtask

    task automatic do_reset();
        idle_check = 0;
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle_check = 1;
    endtask

    // Between requests the cache must never stall.
    always @(negedge clk) begin
        if (idle_check && rst_n)
            checkOutput("idle_stall", {31'h0, clk_stall}, 32'h0);
    end

    initial begin
        int st;
        int diffs;
        logic [31:0] v;
        logic [13:0] a;
        logic        we, re;
        logic [3:0]  m;
        logic [3:0]  masks [5];
        masks[0] = M_LBU; masks[1] = M_LB; masks[2] = M_LHU; masks[3] = M_LH; masks[4] = M_LW;

        for (int i = 0; i < MEM_WORDS; i++) begin
            v = (i == 0) ? 32'h11223344 : ((32'(i) * 32'h9E3779B9) ^ 32'h5A5A0F0F);
            dut.ram[i] <= v;
            ram_model[i] = v;
        end
        model_reset();
        #22;
        checkOutput("reset_read_data", read_data, 32'h0);
        checkOutput("reset_stall", {31'h0, clk_stall}, 32'h0);
        checkOutput("reset_led", {24'h0, led}, 32'h0);
`ifdef DCACHE_STATS_EN
        checkOutput("reset_hits", hit_count, 32'h0);
        checkOutput("reset_misses", miss_count, 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        idle_check = 1;

        // Cold miss then hit on word 0.
        applyStimulus(14'h000, 32'h0, 1'b0, 1'b1, M_LW, st);
        checkOutput("lw0_miss_stall_lit", 32'(st), 32'd6);
        checkOutput("lw0_data_lit", read_data, 32'h11223344);
        applyStimulus(14'h000, 32'h0, 1'b0, 1'b1, M_LW, st);
        checkOutput("lw0_hit_stall_lit", 32'(st), 32'd0);

        // Sub-word stores and loads.
        applyStimulus(14'h001, 32'h000000AB, 1'b1, 1'b0, M_LBU, st);
        applyStimulus(14'h001, 32'h0, 1'b0, 1'b1, M_LBU, st);
        checkOutput("lbu1_lit", read_data, 32'h000000AB);
        applyStimulus(14'h001, 32'h0, 1'b0, 1'b1, M_LB, st);
        checkOutput("lb1_lit", read_data, 32'hFFFFFFAB);
        applyStimulus(14'h002, 32'h0, 1'b0, 1'b1, M_LHU, st);
        checkOutput("lhu2_lit", read_data, 32'h00001122);

        // Three lines in set 0: the third evicts the dirty LRU line 0x000.
        applyStimulus(14'h040, 32'hCAFE0040, 1'b1, 1'b0, M_LW, st);
        applyStimulus(14'h080, 32'hCAFE0080, 1'b1, 1'b1, M_LW, st);
        checkOutput("dirty_evict_stall_lit", 32'(st), 32'd10);
        checkOutput("ram0_writeback_lit", dut.ram[0], 32'h1122AB44);

        // LRU order: touching 0x000 again makes 0x040 the victim.
        do_reset();
        applyStimulus(14'h000, 32'h0, 1'b0, 1'b1, M_LW, st);
        checkOutput("after_reset_data_lit", read_data, 32'h1122AB44);
        applyStimulus(14'h040, 32'h0, 1'b0, 1'b1, M_LW, st);
        applyStimulus(14'h000, 32'h0, 1'b0, 1'b1, M_LW, st);
        applyStimulus(14'h080, 32'h0, 1'b0, 1'b1, M_LW, st);
        checkOutput("lru_clean_evict_lit", 32'(st), 32'd6);
        applyStimulus(14'h000, 32'h0, 1'b0, 1'b1, M_LW, st);
        checkOutput("lru_kept_0x000_lit", 32'(st), 32'd0);
        applyStimulus(14'h040, 32'h0, 1'b0, 1'b1, M_LW, st);
        checkOutput("lru_evicted_0x040_lit", 32'(st), 32'd6);

        // LED write: no stall, cache state untouched.
        applyStimulus(14'h2000, 32'hDEADBEEF, 1'b1, 1'b0, M_LW, st);
        checkOutput("led_lit", {24'h0, led}, 32'h000000EF);
        checkOutput("led_stall_lit", 32'(st), 32'd0);
        applyStimulus(14'h040, 32'h0, 1'b0, 1'b1, M_LW, st);
        checkOutput("led_tags_kept_lit", 32'(st), 32'd0);

        // Reset in the middle of a refill aborts the miss at once.
        do_reset();
        idle_check = 0;
        @(negedge clk);
        addr = 14'h100; memread = 1'b1; memwrite = 1'b0; sign_mask = M_LW;
        @(posedge clk);
        #1;
        checkOutput("refill_stall_start", {31'h0, clk_stall}, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_stall_lit", {31'h0, clk_stall}, 32'h0);
        checkOutput("abort_read_data_lit", read_data, 32'h0);
        memread = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle_check = 1;
        applyStimulus(14'h100, 32'h0, 1'b0, 1'b1, M_LW, st);
        checkOutput("abort_remiss_lit", 32'(st), 32'd6);

        // Randomized traffic concentrated on a few tags to force conflicts.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) < 5) begin
                a  = 14'h2000;
                we = 1'b1;
                re = 1'b0;
            end else begin
                a = 14'(((($urandom_range(0, 5) * SETS + $urandom_range(0, SETS - 1)) * LINE_WORDS
                         + $urandom_range(0, LINE_WORDS - 1)) << 2) | $urandom_range(0, 3));
                a[13:12] = 2'($urandom_range(0, 2));
                we = 1'($urandom_range(0, 1));
                re = we ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            m = masks[$urandom_range(0, 4)];
            applyStimulus(a, $urandom, we, re, m, st);
        end

        // Backing RAM must hold exactly what the evictions wrote.
        diffs = 0;
        for (int i = 0; i < MEM_WORDS; i++)
            if (dut.ram[i] !== ram_model[i]) diffs++;
        checkOutput("ram_image_diffs", 32'(diffs), 32'h0);

        idle_check = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
